// File: rtl/board_composer_pkg.sv
// board_composer_pkg: shared cell codes, FSM states and board dimension defaults
package board_composer_pkg;
  localparam int BOARD_W_DEF = 40;
  localparam int BOARD_H_DEF = 40;
  localparam int POS_W_DEF   = 11;
  localparam int MAX_LEN_DEF = 18;
  localparam logic [1:0] CELL_EMPTY  = 2'd0;
  localparam logic [1:0] CELL_SNAKE1 = 2'd1;
  localparam logic [1:0] CELL_SNAKE2 = 2'd2;
  localparam logic [1:0] CELL_APPLE  = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_APPLE = 3'd2,
    ST_S1    = 3'd3,
    ST_S2    = 3'd4,
    ST_FIN   = 3'd5
  } state_t;
endpackage

// File: rtl/board_composer_ram.sv
// board_ram: cell storage with one write port, registered renderer read and a combinational check read
module board_ram import board_composer_pkg::*; #(
  parameter int CELLS = BOARD_W_DEF * BOARD_H_DEF,
  parameter int AW    = POS_W_DEF
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_code,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_code,
  input  logic [AW-1:0] chk_addr,
  output logic [1:0]    chk_code
);
  localparam int IW = CELLS > 1 ? $clog2(CELLS) : 1;
  localparam logic [AW:0] LIM = (AW+1)'(CELLS);
  logic [1:0] mem_q [CELLS];
  logic [1:0] rd_code_q;
  assign rd_code  = rd_code_q;
  assign chk_code = ({1'b0, chk_addr} < LIM) ? mem_q[chk_addr[IW-1:0]] : CELL_EMPTY;
  // cell writes and registered read; out-of-range reads return empty
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= CELL_EMPTY;
      rd_code_q <= CELL_EMPTY;
    end else begin
      if (we) mem_q[wr_addr[IW-1:0]] <= wr_code;
      rd_code_q <= ({1'b0, rd_addr} < LIM) ? mem_q[rd_addr[IW-1:0]] : CELL_EMPTY;
    end
  end
endmodule

// File: rtl/board_composer.sv
// board_composer: per-frame rebuild of the game board from snake and apple snapshots
module board_composer import board_composer_pkg::*; #(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int POS_W   = POS_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                     iVGA_CLK,
  input  logic                     iRST_n,
  input  logic                     frame_start,
  input  logic [MAX_LEN*POS_W-1:0] snake1,
  input  logic [MAX_LEN*POS_W-1:0] snake2,
  input  logic [31:0]              length1,
  input  logic [31:0]              length2,
  input  logic [POS_W-1:0]         apple,
  input  logic                     apple_en,
  input  logic [POS_W-1:0]         rd_addr,
  output logic [1:0]               rd_code,
  output logic                     isDrawing,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     collide,
  output logic                     apple_hit,
  output logic                     pos_err
);
  localparam int CELLS = BOARD_W * BOARD_H;
  localparam int SW = $clog2(MAX_LEN + 1);
  localparam logic [POS_W:0]   LIM  = (POS_W+1)'(CELLS);
  localparam logic [POS_W-1:0] LAST = POS_W'(CELLS - 1);
  localparam logic [SW-1:0]    LMAX = SW'(MAX_LEN);
  state_t state_q, state_d;
  logic [POS_W-1:0] idx_q, idx_d, apple_q, seg_pos, cur_pos;
  logic [SW-1:0] seg_q, seg_d, l1_q, l2_q, l1_d, l2_d;
  logic [MAX_LEN*POS_W-1:0] s1_q, s2_q;
  logic apple_en_q, busy_q, draw_q, done_q, collide_q, hit_q, err_q;
  logic accept, active_seg, in_rng, we, check_pos;
  logic [1:0] wr_code, chk_code;
  int seg_off;
  assign accept     = state_q == ST_IDLE && frame_start;
  assign active_seg = state_q == ST_S1 || state_q == ST_S2;
  assign seg_off    = int'(seg_q) * POS_W;
  assign seg_pos    = state_q == ST_S2 ? s2_q[seg_off +: POS_W] : s1_q[seg_off +: POS_W];
  assign cur_pos    = state_q == ST_CLEAR ? idx_q : state_q == ST_APPLE ? apple_q : seg_pos;
  assign in_rng     = {1'b0, cur_pos} < LIM;
  assign check_pos  = active_seg || (state_q == ST_APPLE && apple_en_q);
  assign we         = state_q == ST_CLEAR || (in_rng && check_pos);
  assign wr_code    = state_q == ST_S1 ? CELL_SNAKE1 : state_q == ST_S2 ? CELL_SNAKE2 :
                      state_q == ST_APPLE ? CELL_APPLE : CELL_EMPTY;
  assign l1_d       = length1 > 32'(MAX_LEN) ? LMAX : length1[SW-1:0];
  assign l2_d       = length2 > 32'(MAX_LEN) ? LMAX : length2[SW-1:0];
  assign isDrawing  = draw_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign collide    = collide_q;
  assign apple_hit  = hit_q;
  assign pos_err    = err_q;
  // sequencing: clear sweep, apple, snake1 segments, snake2 segments, finish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    case (state_q)
      ST_IDLE:  if (frame_start) begin state_d = ST_CLEAR; idx_d = '0; end
      ST_CLEAR: if (idx_q == LAST) state_d = ST_APPLE; else idx_d = idx_q + 1'b1;
      ST_APPLE: begin
        seg_d   = '0;
        state_d = l1_q != '0 ? ST_S1 : l2_q != '0 ? ST_S2 : ST_FIN;
      end
      ST_S1: if (seg_q == l1_q - 1'b1) begin
        seg_d   = '0;
        state_d = l2_q != '0 ? ST_S2 : ST_FIN;
      end else seg_d = seg_q + 1'b1;
      ST_S2:   if (seg_q == l2_q - 1'b1) state_d = ST_FIN; else seg_d = seg_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end
  // state, snapshot registers, status outputs and sticky per-frame flags
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seg_q      <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      apple_q    <= '0;
      apple_en_q <= 1'b0;
      busy_q     <= 1'b0;
      draw_q     <= 1'b0;
      done_q     <= 1'b0;
      collide_q  <= 1'b0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      done_q  <= state_q == ST_FIN;
      if (accept) begin
        s1_q       <= snake1;
        s2_q       <= snake2;
        apple_q    <= apple;
        apple_en_q <= apple_en;
        l1_q       <= l1_d;
        l2_q       <= l2_d;
        busy_q     <= 1'b1;
        draw_q     <= 1'b0;
        collide_q  <= 1'b0;
        hit_q      <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        if (state_q == ST_FIN) begin
          busy_q <= 1'b0;
          draw_q <= 1'b1;
        end
        if (active_seg && in_rng && (chk_code == CELL_SNAKE1 || chk_code == CELL_SNAKE2)) collide_q <= 1'b1;
        if (active_seg && in_rng && chk_code == CELL_APPLE) hit_q <= 1'b1;
        if (check_pos && !in_rng) err_q <= 1'b1;
      end
    end
  end
  board_ram #(.CELLS(CELLS), .AW(POS_W)) u_ram (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n  (iRST_n),
    .we      (we),
    .wr_addr (cur_pos),
    .wr_code (wr_code),
    .rd_addr (rd_addr),
    .rd_code (rd_code),
    .chk_addr(cur_pos),
    .chk_code(chk_code)
  );
endmodule

// File: doc/board_composer.md
Name: board_composer

Overview:
- Producer side of the game board consumed by the VGA renderer.
- Once per frame, on a frame_start pulse issued at the start of vertical blank, it snapshots both snakes' segment lists and the apple position.
- It rebuilds a BOARD_W x BOARD_H array of 2-bit cell codes one cell per clock, then flags the board stable (isDrawing) for the renderer.
- The renderer reads cells through a registered read port; game logic reads collision and apple-eaten flags.

Parameters:
- BOARD_W, 40, board columns.
- BOARD_H, 40, board rows; CELLS = BOARD_W*BOARD_H.
- POS_W, 11, cell-index width; must satisfy 2^POS_W >= CELLS.
- MAX_LEN, 18, maximum segments per snake.

Ports:
- iVGA_CLK  in  1  clock.
- iRST_n  in  1  reset.
- frame_start  in  1  single-cycle compose request.
- snake1  in  MAX_LEN*POS_W  segment i at [i*POS_W +: POS_W]; i=0 is the head.
- snake2  in  MAX_LEN*POS_W  same packing as snake1.
- length1  in  32  segment count of snake1.
- length2  in  32  segment count of snake2.
- apple  in  POS_W  apple cell index.
- apple_en  in  1  apple present.
- rd_addr  in  POS_W  renderer cell index (row*BOARD_W+col).
- rd_code  out  2  cell code: 0 empty, 1 snake1, 2 snake2, 3 apple.
- isDrawing  out  1  board complete and stable.
- busy  out  1  composition in progress.
- frame_done  out  1  one-cycle pulse at end of composition.
- collide  out  1  a snake write landed on a snake cell this frame.
- apple_hit  out  1  a snake write landed on the apple cell this frame.
- pos_err  out  1  an out-of-range position was seen this frame.

Behaviour:
- Reset iRST_n is asynchronous, active-low; clock is iVGA_CLK.
- Reset values: all cells 0, state IDLE, rd_code=0, isDrawing=0, busy=0, frame_done=0, collide=0, apple_hit=0, pos_err=0.
- Storage: CELLS x 2-bit register array, written at one cell per clock.
- Read port:
  - rd_code is registered with 1-cycle latency from rd_addr.
  - rd_addr >= CELLS returns 0.
  - Reads are permitted at any time; content is defined only while isDrawing=1.
- FSM states: IDLE, CLEAR, APPLE, S1, S2, FIN.
- IDLE:
  - frame_start=1 latches snake1, snake2, apple and apple_en.
  - It latches L1 = min(length1, MAX_LEN) and L2 = min(length2, MAX_LEN).
  - It clears collide, apple_hit and pos_err.
  - Next state is CLEAR; busy=1 and isDrawing=0 from the next cycle.
- CLEAR: writes 0 to cells 0..CELLS-1, one per cycle, for CELLS cycles.
- APPLE: takes 1 cycle; writes code 3 if apple_en and apple < CELLS.
- S1: takes L1 cycles; writes code 1 at segments 0..L1-1. L1=0 skips to S2.
- S2: takes L2 cycles; writes code 2 at segments 0..L2-1. L2=0 skips to FIN.
- Per-write checks in S1/S2, using the pre-write cell value:
  - Value 1 or 2 sets collide.
  - Value 3 sets apple_hit.
  - The write always happens, so later writes win.
- Any segment or apple index >= CELLS sets pos_err; the write is suppressed but the cycle is still consumed.
- FIN: 1 cycle; frame_done=1, busy=0, isDrawing=1 from the next cycle; then returns to IDLE.
- Latency: frame_done is high exactly CELLS + L1 + L2 + 2 cycles after the edge that sampled frame_start.
- Flags hold their value until the next accepted frame_start.
- frame_start while busy is ignored, with no queueing.
- Lengths are unsigned; any value > MAX_LEN clamps to MAX_LEN.
- Reset mid-composition returns to reset values immediately.

Decomposition:
- Shared package holds:
  - cell-code constants CELL_EMPTY=0, CELL_SNAKE1=1, CELL_SNAKE2=2, CELL_APPLE=3;
  - the FSM state enum;
  - the board dimension defaults.
- Read port and storage array: one sub-module, board_ram (sync write, registered read, async clear on reset).
- FSM and segment-indexing counters live in board_composer.

Test Plan:
- Reset: release iRST_n, then sweep all rd_addr -> rd_code=0, isDrawing=0, busy=0, every flag 0.
- Basic compose (BOARD_W=BOARD_H=8):
  - Stimulus: snake1={10,11,12}, length1=3, length2=0, apple=40, apple_en=1; pulse frame_start.
  - Required: frame_done exactly 69 cycles later.
  - Required: cells 10,11,12 read 1, cell 40 reads 3, all others 0; collide=0, apple_hit=0.
- Overlap: as above plus snake2={11,19}, length2=2 -> cell 11 reads 2, cell 19 reads 2, collide=1; frame_done at 71 cycles.
- Apple eaten: snake1 head=40, apple=40 -> cell 40 reads 1, apple_hit=1, collide=0.
- Range and clamp:
  - Stimulus: length1=25 with MAX_LEN=18, segment 5 = 70 (>= 64).
  - Required: pos_err=1, only 17 cells written, frame_done at 64+18+2=84 cycles.
- Control:
  - Second frame_start at cycle 10 of busy -> ignored; frame_done pulses once.
  - iRST_n low during CLEAR -> busy=0 and all cells 0 after release.
